// File: rtl/eth_sniffer_pkg.sv
// Shared definitions for the comparator configuration path: sequencer states,
// Avalon register map and control-word bit positions.
package eth_sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } cfg_state_t;

    localparam int CTRL_ADDR   = 0;
    localparam int STATUS_ADDR = 1;
    localparam int COUNT_ADDR  = 2;
    localparam int STAGE_BASE  = 16;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ABORT_BIT  = 1;

endpackage

// File: rtl/cfg_staging_regs.sv
// Staging register file for comparator config words: one synchronous write
// port, two combinational read ports (host side and sequencer side).
module cfg_staging_regs #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [IDX_W-1:0]  i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/comp_config_sequencer.sv
// Host-facing loader: stages comparator config words over Avalon-MM and, on
// commit, streams them one per accepted beat into the comparator banks.
module comp_config_sequencer
    import eth_sniffer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 5,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [IDX_W-1:0]  cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_we,
    input  logic              cfg_ready,
    output logic              cfg_busy,
    output logic              update_done
);

    cfg_state_t        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_count;
    logic [DATA_W-1:0] r_rdata;

    logic              w_stage_hit;
    logic              w_stage_we;
    logic              w_ctrl_wr;
    logic              w_commit;
    logic              w_abort;
    logic [IDX_W-1:0]  w_seq_raddr;
    logic [DATA_W-1:0] w_seq_rdata;
    logic [DATA_W-1:0] w_avs_rdata;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_stage_hit = (avs_address >= ADDR_W'(STAGE_BASE)) &&
                         (avs_address <= ADDR_W'(STAGE_BASE + DEPTH - 1));
    assign w_ctrl_wr   = avs_write && (avs_address == ADDR_W'(CTRL_ADDR));
    assign w_abort     = w_ctrl_wr && avs_writedata[CTRL_ABORT_BIT];
    assign w_commit    = w_ctrl_wr && avs_writedata[CTRL_COMMIT_BIT] && !avs_writedata[CTRL_ABORT_BIT];

    // Staging writes are held off for the whole load so a load always sends a consistent snapshot.
    assign avs_waitrequest = avs_write && w_stage_hit && r_busy;
    assign w_stage_we      = avs_write && w_stage_hit && !r_busy;

    // Sequencer port prefetches the word for the next beat so cfg_data is registered.
    assign w_seq_raddr = (r_state == IDLE) ? '0 : r_idx + 1'b1;

    cfg_staging_regs #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_staging (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_we      (w_stage_we),
        .i_waddr   (avs_address[IDX_W-1:0]),
        .i_wdata   (avs_writedata),
        .i_raddr_a (avs_address[IDX_W-1:0]),
        .o_rdata_a (w_avs_rdata),
        .i_raddr_b (w_seq_raddr),
        .o_rdata_b (w_seq_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_commit) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                        r_data  <= w_seq_rdata;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (cfg_ready) begin
                        if (r_idx == IDX_W'(DEPTH - 1)) begin
                            r_state <= DONE;
                            r_we    <= 1'b0;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_data <= w_seq_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_count <= r_count + 16'd1;
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (avs_address == ADDR_W'(STATUS_ADDR)) begin
            w_rd_mux = {{(DATA_W-2){1'b0}}, r_done, r_busy};
        end else if (avs_address == ADDR_W'(COUNT_ADDR)) begin
            w_rd_mux = {{(DATA_W-16){1'b0}}, r_count};
        end else if (w_stage_hit) begin
            w_rd_mux = w_avs_rdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rdata <= '0;
        end else if (avs_read) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign avs_readdata = r_rdata;
    assign cfg_addr     = r_idx;
    assign cfg_data     = r_data;
    assign cfg_we       = r_we;
    assign cfg_busy     = r_busy;
    assign update_done  = r_done;

endmodule

// File: tb/tb_comp_config_sequencer.sv
// Randomized bench for comp_config_sequencer against a staging-array reference model.
module tb_comp_config_sequencer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [ADDR_W-1:0] avs_address = '0;
    logic              avs_write = 1'b0;
    logic [DATA_W-1:0] avs_writedata = '0;
    logic              avs_read = 1'b0;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;
    logic [IDX_W-1:0]  cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_we;
    logic              cfg_ready = 1'b1;
    logic              cfg_busy;
    logic              update_done;

    always #5 clk = ~clk;

    comp_config_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_we          (cfg_we),
        .cfg_ready       (cfg_ready),
        .cfg_busy        (cfg_busy),
        .update_done     (update_done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: staging contents, commit counter, done flag, and the snapshot a load must send.
    logic [31:0] stage_m [DEPTH];
    logic [31:0] snap    [DEPTH];
    int          cnt_m  = 0;
    bit          done_m = 0;

    typedef struct {
        int          c;
        int          a;
        logic [31:0] d;
    } beat_t;
    beat_t beat_q [$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          mode = 0;
    int          ph = 0;
    bit          hold = 0;
    logic [31:0] h_addr;
    logic [31:0] h_data;

    always @(negedge clk) begin
        beat_t b;
        case (mode)
            0:       cfg_ready = 1'b1;
            1: begin
                cfg_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end
            default: cfg_ready = 1'($urandom_range(0, 1));
        endcase
        if (n_rst && cfg_we) begin
            if (hold) begin
                chk("hold_addr", 32'(cfg_addr), h_addr);
                chk("hold_data", cfg_data, h_data);
            end
            if (cfg_ready) begin
                b.c = cyc;
                b.a = int'(cfg_addr);
                b.d = cfg_data;
                beat_q.push_back(b);
            end
            hold   = !cfg_ready;
            h_addr = 32'(cfg_addr);
            h_data = cfg_data;
        end else begin
            hold = 0;
        end
    end

    int acc_cyc;
    int last_stalls;
    bit acc_busy;
    int commit_cyc;
    logic [31:0] rd_data;

    task automatic av_write(input int addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        #1;
        avs_address   = ADDR_W'(addr);
        avs_writedata = data;
        avs_write     = 1'b1;
        #1;
        while (avs_waitrequest && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("wr_timeout", 32'(avs_waitrequest), 0);
        acc_busy = cfg_busy;
        @(negedge clk);
        avs_write   = 1'b0;
        acc_cyc     = cyc;
        last_stalls = n;
    endtask

    task automatic av_read(input int addr);
        @(negedge clk);
        #1;
        avs_address = ADDR_W'(addr);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        #1;
        rd_data = avs_readdata;
    endtask

    task automatic stage_write(input int idx, input logic [31:0] data);
        av_write(16 + idx, data);
        stage_m[idx] = data;
    endtask

    task automatic start_load();
        for (int i = 0; i < DEPTH; i++) snap[i] = stage_m[i];
        beat_q.delete();
        done_m = 0;
        av_write(0, 32'h1);
        commit_cyc = acc_cyc;
    endtask

    task automatic finish_load(input bit lat);
        int n = 0;
        int dc;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!update_done && n < 400);
        dc = cyc;
        chk("done_seen", 32'(update_done), 1);
        chk("busy_after", 32'(cfg_busy), 0);
        chk("we_after", 32'(cfg_we), 0);
        cnt_m  = (cnt_m + 1) % 65536;
        done_m = 1;
        chk("beat_cnt", beat_q.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < beat_q.size(); i++) begin
            chk("beat_addr", beat_q[i].a, i);
            chk("beat_data", beat_q[i].d, snap[i]);
        end
        if (lat && beat_q.size() == DEPTH) begin
            chk("lat_first_we", beat_q[0].c, commit_cyc);
            chk("lat_last_we", beat_q[DEPTH-1].c, commit_cyc + DEPTH - 1);
            chk("lat_done", dc, commit_cyc + DEPTH + 1);
        end
        av_read(2);
        chk("count", rd_data, cnt_m);
        av_read(1);
        chk("status", rd_data, {30'd0, done_m, 1'b0});
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) stage_m[i] = '0;

        // 1: activity while in reset, then release
        repeat (2) @(negedge clk);
        avs_address = 5'd16; avs_writedata = 32'hFFFF_0000; avs_write = 1'b1;
        repeat (2) @(negedge clk);
        avs_write = 1'b0; avs_address = '0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("rst_we", 32'(cfg_we), 0);
        chk("rst_busy", 32'(cfg_busy), 0);
        chk("rst_done", 32'(update_done), 0);
        chk("rst_addr", 32'(cfg_addr), 0);
        chk("rst_data", cfg_data, 0);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_wait", 32'(avs_waitrequest), 0);
        av_read(1);  chk("rst_status", rd_data, 0);
        av_read(2);  chk("rst_count", rd_data, 0);
        av_read(16); chk("rst_word16", rd_data, 0);

        // 2: ascending pattern, full-rate load with latency check
        for (int i = 0; i < DEPTH; i++) stage_write(i, 32'hA0 + i);
        av_write(5, 32'hDEAD);
        av_read(5); chk("unmapped_rd", rd_data, 0);
        av_read(16 + 7); chk("stage_rd", rd_data, stage_m[7]);
        @(negedge clk); #1;
        chk("rd_hold", avs_readdata, rd_data);
        mode = 0;
        start_load();
        finish_load(1);

        // 3: random data, 1-0-0-1 ready pattern, then random rounds
        for (int i = 0; i < DEPTH; i++) stage_write(i, $urandom);
        mode = 1; ph = 0;
        start_load();
        finish_load(0);
        for (int r = 0; r < 3; r++) begin
            int k = $urandom_range(0, DEPTH - 1);
            for (int i = 0; i < 4; i++) stage_write($urandom_range(0, DEPTH - 1), $urandom);
            av_read(16 + k); chk("rand_stage_rd", rd_data, stage_m[k]);
            mode = $urandom_range(0, 2);
            start_load();
            finish_load(mode == 0);
        end

        // 4: staging write during a load stalls and lands only in the next load
        mode = 2;
        start_load();
        av_write(20, 32'h55);
        chk("wait_seen", 32'(last_stalls > 0), 1);
        chk("wr_busy_at_accept", 32'(acc_busy), 0);
        finish_load(0);
        stage_m[4] = 32'h55;
        start_load();
        finish_load(0);
        if (beat_q.size() > 4) chk("new_word4", beat_q[4].d, 32'h55);

        // 5: abort mid-load, then commit+abort from idle
        mode = 0;
        start_load();
        n = 0;
        while (beat_q.size() < 6 && n < 100) begin @(negedge clk); #1; n++; end
        av_write(0, 32'h2);
        #1;
        chk("abort_we", 32'(cfg_we), 0);
        chk("abort_busy", 32'(cfg_busy), 0);
        chk("abort_done", 32'(update_done), 0);
        chk("abort_partial", 32'(beat_q.size() < DEPTH), 1);
        av_read(2); chk("abort_count", rd_data, cnt_m);
        av_read(1); chk("abort_status", rd_data, 0);
        beat_q.delete();
        av_write(0, 32'h3);
        repeat (5) @(negedge clk);
        #1;
        chk("both_no_beats", beat_q.size(), 0);
        chk("both_busy", 32'(cfg_busy), 0);
        av_read(1); chk("both_status", rd_data, 0);

        // 6: reset in the middle of a load
        for (int i = 0; i < DEPTH; i++) stage_write(i, $urandom | 32'h1);
        mode = 0;
        start_load();
        n = 0;
        while (beat_q.size() < 9 && n < 100) begin @(negedge clk); #1; n++; end
        n_rst = 1'b0;
        #1;
        chk("mrst_we", 32'(cfg_we), 0);
        chk("mrst_done", 32'(update_done), 0);
        chk("mrst_busy", 32'(cfg_busy), 0);
        for (int i = 0; i < DEPTH; i++) stage_m[i] = '0;
        cnt_m = 0;
        done_m = 0;
        @(negedge clk);
        n_rst = 1'b1;
        av_read(3); chk("mrst_rd3", rd_data, 0);
        n = $urandom_range(0, DEPTH - 1);
        av_read(16 + n); chk("mrst_stage", rd_data, 0);
        av_read(2); chk("mrst_count", rd_data, 0);
        start_load();
        finish_load(1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
